// File: rtl/y_wave_pkg.sv
// Shared types and constants for the y_wave_draw trace renderer.
// Holds the FSM state encoding, the video control packet layout and the RGB width.
package y_wave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CTRL,
        ACTIVE,
        DRAIN
    } state_t;

    // Control packet: {width, height, interlace}
    localparam int unsigned CTRL_WIDTH_W     = 16;
    localparam int unsigned CTRL_HEIGHT_W    = 16;
    localparam int unsigned CTRL_INTERLACE_W = 4;
    localparam int unsigned CTRL_LEN         = CTRL_WIDTH_W + CTRL_HEIGHT_W + CTRL_INTERLACE_W;

    localparam int unsigned RGB_W = 24;

endpackage

// File: rtl/y_wave_hit.sv
// Per-channel hit test for one pixel.
// Ports:
//   s     current-column sample
//   p     previous-column sample (equal to s at column 0)
//   y     row being rendered
//   mode  0 = dot (y == s), 1 = line (y between p and s, both clipped to HEIGHT-1)
//   hit_c combinational hit flag
module y_wave_hit
    import y_wave_pkg::*;
#(
    parameter int unsigned Y_BITS = 8,
    parameter int unsigned HEIGHT = 256
) (
    input  logic [Y_BITS-1:0] s,
    input  logic [Y_BITS-1:0] p,
    input  logic [Y_BITS-1:0] y,
    input  logic              mode,
    output logic              hit_c
);

    localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(HEIGHT - 1);

    logic [Y_BITS-1:0] s_clip;
    logic [Y_BITS-1:0] p_clip;
    logic [Y_BITS-1:0] lo;
    logic [Y_BITS-1:0] hi;

    // Out-of-range samples never match a row in dot mode since y <= HEIGHT-1.
    always_comb begin
        s_clip = (s > Y_MAX) ? Y_MAX : s;
        p_clip = (p > Y_MAX) ? Y_MAX : p;
        lo     = (s_clip < p_clip) ? s_clip : p_clip;
        hi     = (s_clip < p_clip) ? p_clip : s_clip;
        if (mode) begin
            hit_c = (y >= lo) && (y <= hi);
        end else begin
            hit_c = (y == s);
        end
    end

endmodule

// File: rtl/y_wave_draw.sv
// Multi-channel waveform renderer producing a WIDTH x HEIGHT RGB pixel stream.
// Ports:
//   clk, rst                      pixel clock, async active-high reset
//   run, line_mode, ch_enable     frame control (mode/enable latched per frame)
//   ch_color                      24-bit colour per channel
//   ram_addr, ram_rd, ram_rddata  sample RAM read port (1-cycle read latency)
//   video_data/valid/ready        ready/valid pixel stream
//   frame_sync                    pulse on acceptance of the last pixel
//   out_control_data/valid        control packet pulsed before each frame
module y_wave_draw
    import y_wave_pkg::*;
#(
    parameter int unsigned      WIDTH    = 256,
    parameter int unsigned      HEIGHT   = 256,
    parameter int unsigned      X_BITS   = 8,
    parameter int unsigned      Y_BITS   = 8,
    parameter int unsigned      CHANNELS = 2,
    parameter logic [RGB_W-1:0] BG_COLOR = 24'h000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic                         line_mode,
    input  logic [RGB_W*CHANNELS-1:0]    ch_color,
    input  logic [CHANNELS-1:0]          ch_enable,
    output logic [X_BITS-1:0]            ram_addr,
    output logic                         ram_rd,
    input  logic [Y_BITS*CHANNELS-1:0]   ram_rddata,
    output logic [RGB_W-1:0]             video_data,
    output logic                         video_valid,
    input  logic                         video_ready,
    output logic                         frame_sync,
    output logic [CTRL_LEN-1:0]          out_control_data,
    output logic                         out_control_valid
);

    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0] Y_TOP  = Y_BITS'(HEIGHT - 1);

    state_t                           state;
    state_t                           state_nxt;
    logic                             ctrl_valid_nxt;
    logic                             en;
    logic [X_BITS-1:0]                x_cnt;
    logic [Y_BITS-1:0]                y_cnt;
    logic                             mode_q;
    logic [CHANNELS-1:0]              enable_q;

    logic                             s1_valid;
    logic                             s1_first;
    logic                             s1_x_last;
    logic [Y_BITS-1:0]                s1_y;
    logic                             video_x_last;
    logic                             video_y0;

    logic [CHANNELS-1:0][Y_BITS-1:0]  samp;
    logic [CHANNELS-1:0][Y_BITS-1:0]  prev_s;
    logic [CHANNELS-1:0][Y_BITS-1:0]  p_sel;
    logic [CHANNELS-1:0]              hit;
    logic [RGB_W-1:0]                 pix_c;

    assign en               = !video_valid || video_ready;
    assign ram_addr         = x_cnt;
    assign frame_sync       = video_valid && video_ready && video_x_last && video_y0;
    assign out_control_data = {CTRL_WIDTH_W'(WIDTH), CTRL_HEIGHT_W'(HEIGHT), CTRL_INTERLACE_W'(0)};

    // Next state, RAM read strobe and control-packet request.
    always_comb begin
        state_nxt      = state;
        ram_rd         = 1'b0;
        ctrl_valid_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (run) state_nxt = CTRL;
            end
            CTRL: begin
                state_nxt = ACTIVE;
            end
            ACTIVE: begin
                ram_rd = en;
                if (en && (x_cnt == X_LAST) && (y_cnt == '0)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (frame_sync) state_nxt = run ? CTRL : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        ctrl_valid_nxt = (state_nxt == CTRL);
    end

    // State, control pulse, per-frame settings and scan counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            out_control_valid <= 1'b0;
            mode_q            <= 1'b0;
            enable_q          <= '0;
            x_cnt             <= '0;
            y_cnt             <= Y_TOP;
        end else begin
            state             <= state_nxt;
            out_control_valid <= ctrl_valid_nxt;
            if (state == CTRL) begin
                mode_q   <= line_mode;
                enable_q <= ch_enable;
                x_cnt    <= '0;
                y_cnt    <= Y_TOP;
            end else if (ram_rd) begin
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= (y_cnt == '0) ? Y_TOP : y_cnt - Y_BITS'(1);
                end else begin
                    x_cnt <= x_cnt + X_BITS'(1);
                end
            end
        end
    end

    // Channel hit tests; the previous sample is replaced by the current one at column 0.
    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
        assign samp[g]  = ram_rddata[g*Y_BITS +: Y_BITS];
        assign p_sel[g] = s1_first ? samp[g] : prev_s[g];

        y_wave_hit #(
            .Y_BITS (Y_BITS),
            .HEIGHT (HEIGHT)
        ) u_hit (
            .s     (samp[g]),
            .p     (p_sel[g]),
            .y     (s1_y),
            .mode  (mode_q),
            .hit_c (hit[g])
        );
    end

    // Lowest-index enabled channel with a hit wins.
    always_comb begin
        pix_c = BG_COLOR;
        for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
            if (enable_q[k] && hit[k]) pix_c = ch_color[k*RGB_W +: RGB_W];
        end
    end

    // Stage 1 and output register; everything stalls together when en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_first     <= 1'b0;
            s1_x_last    <= 1'b0;
            s1_y         <= '0;
            video_valid  <= 1'b0;
            video_data   <= '0;
            video_x_last <= 1'b0;
            video_y0     <= 1'b0;
            prev_s       <= '0;
        end else if (en) begin
            s1_valid     <= ram_rd;
            s1_first     <= (x_cnt == '0);
            s1_x_last    <= (x_cnt == X_LAST);
            s1_y         <= y_cnt;
            video_valid  <= s1_valid;
            video_x_last <= s1_x_last;
            video_y0     <= (s1_y == '0);
            if (s1_valid) begin
                video_data <= pix_c;
                prev_s     <= samp;
            end
        end
    end

endmodule

// File: tb/tb_y_wave_draw.sv
// Self-checking bench for y_wave_draw on an 8x8 two-channel configuration.
module tb_y_wave_draw;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int NC = 2;
    localparam int NPIX = W * H;
    localparam logic [23:0] BG    = 24'h123456;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [35:0] CTRL_EXP = {16'd8, 16'd8, 4'd0};

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        line_mode;
    logic [47:0] ch_color;
    logic [1:0]  ch_enable;
    logic [2:0]  ram_addr;
    logic        ram_rd;
    logic [15:0] ram_rddata = '0;
    logic [23:0] video_data;
    logic        video_valid;
    logic        video_ready;
    logic        frame_sync;
    logic [35:0] out_control_data;
    logic        out_control_valid;

    y_wave_draw #(
        .WIDTH(W), .HEIGHT(H), .X_BITS(3), .Y_BITS(8), .CHANNELS(NC), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .line_mode(line_mode),
        .ch_color(ch_color), .ch_enable(ch_enable),
        .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_rddata(ram_rddata),
        .video_data(video_data), .video_valid(video_valid), .video_ready(video_ready),
        .frame_sync(frame_sync),
        .out_control_data(out_control_data), .out_control_valid(out_control_valid)
    );

    always #5 clk = ~clk;

    // Sample RAM: one-cycle read latency, output held while ram_rd is low.
    logic [7:0] mem [NC][W];
    always @(posedge clk) if (ram_rd) ram_rddata <= {mem[1][ram_addr], mem[0][ram_addr]};

    int checks = 0;
    int errors = 0;

    // Stream monitor
    logic [23:0] cap_q [$];
    bit          sync_q [$];
    logic [23:0] dot_q [$];
    logic [23:0] exp_q [$];
    int          ctrl_cnt, sync_cnt, stray_sync, hold_err;
    int          cyc = 0, first_rd = -1, first_vv = -1;
    logic [35:0] ctrl_data;
    logic        stall_q = 1'b0;
    logic [23:0] stall_data;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (out_control_valid) begin
                ctrl_cnt++;
                ctrl_data = out_control_data;
                first_rd  = -1;
                first_vv  = -1;
            end
            if (ram_rd && first_rd < 0) first_rd = cyc;
            if (video_valid && first_vv < 0) first_vv = cyc;
            if (stall_q && (video_valid !== 1'b1 || video_data !== stall_data)) hold_err++;
            if (video_valid && video_ready) begin
                cap_q.push_back(video_data);
                sync_q.push_back(frame_sync);
                if (frame_sync) sync_cnt++;
            end else if (frame_sync) begin
                stray_sync++;
            end
            stall_q    = video_valid && !video_ready;
            stall_data = video_data;
        end
    end

    // Reference frame: row order HEIGHT-1 down to 0, columns 0..WIDTH-1.
    task automatic build_expected(input bit mode, input logic [1:0] en, input logic [47:0] col);
        exp_q.delete();
        for (int y = H - 1; y >= 0; y--) begin
            for (int x = 0; x < W; x++) begin
                logic [23:0] c;
                c = BG;
                for (int k = NC - 1; k >= 0; k--) begin
                    int s, p, lo, hi;
                    bit h;
                    s = int'(mem[k][x]);
                    p = (x == 0) ? s : int'(mem[k][x-1]);
                    if (mode) begin
                        if (s > H - 1) s = H - 1;
                        if (p > H - 1) p = H - 1;
                        lo = (s < p) ? s : p;
                        hi = (s < p) ? p : s;
                        h  = (y >= lo) && (y <= hi);
                    end else begin
                        h = (s == y);
                    end
                    if (en[k] && h) c = col[24*k +: 24];
                end
                exp_q.push_back(c);
            end
        end
    endtask

    // Runs one frame: run held until the control pulse, stopped afterwards.
    task automatic run_frame(input int ready_pct, output bit ok);
        cap_q.delete();
        sync_q.delete();
        ctrl_cnt = 0; sync_cnt = 0; stray_sync = 0; hold_err = 0;
        ok  = 1'b0;
        run = 1'b1;
        for (int b = 0; b < 3000; b++) begin
            @(posedge clk); #1;
            video_ready = ($urandom_range(99) < ready_pct);
            if (ctrl_cnt > 0) run = 1'b0;
            if (sync_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        run = 1'b0;
        video_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; run = 1'b0; line_mode = 1'b0; ch_enable = 2'b01;
        ch_color = {GREEN, RED}; video_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (video_valid !== 1'b0) begin errors++; $display("FAIL reset video_valid got %b exp 0", video_valid); end
        checks++; if (video_data !== 24'h0) begin errors++; $display("FAIL reset video_data got %h exp 0", video_data); end
        checks++; if (ram_rd !== 1'b0) begin errors++; $display("FAIL reset ram_rd got %b exp 0", ram_rd); end
        checks++; if (ram_addr !== 3'd0) begin errors++; $display("FAIL reset ram_addr got %0d exp 0", ram_addr); end
        checks++; if (out_control_valid !== 1'b0) begin errors++; $display("FAIL reset ctrl_valid got %b exp 0", out_control_valid); end
        checks++; if (frame_sync !== 1'b0) begin errors++; $display("FAIL reset frame_sync got %b exp 0", frame_sync); end
        checks++; if (out_control_data !== CTRL_EXP) begin errors++; $display("FAIL reset ctrl_data got %h exp %h", out_control_data, CTRL_EXP); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_dot;
        bit ok;
        for (int x = 0; x < W; x++) begin mem[0][x] = 8'(x); mem[1][x] = 8'd200; end
        line_mode = 1'b0; ch_enable = 2'b01; ch_color = {GREEN, RED};
        build_expected(1'b0, 2'b01, ch_color);
        run_frame(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL dot frame_done got 0 exp 1"); end
        checks++; if (ctrl_cnt !== 1) begin errors++; $display("FAIL dot ctrl_pulses got %0d exp 1", ctrl_cnt); end
        checks++; if (ctrl_data !== CTRL_EXP) begin errors++; $display("FAIL dot ctrl_data got %h exp %h", ctrl_data, CTRL_EXP); end
        checks++; if (first_vv - first_rd !== 2) begin errors++; $display("FAIL dot latency got %0d exp 2", first_vv - first_rd); end
        checks++; if (cap_q.size() !== NPIX) begin errors++; $display("FAIL dot pixel_count got %0d exp %0d", cap_q.size(), NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            logic [23:0] got;
            got = (i < cap_q.size()) ? cap_q[i] : 24'hx;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL dot pixel %0d got %h exp %h", i, got, exp_q[i]); end
        end
        checks++; if (sync_q.size() != NPIX || sync_q[NPIX-1] !== 1'b1 || sync_cnt !== 1 || stray_sync !== 0)
            begin errors++; $display("FAIL dot frame_sync count got %0d stray %0d exp 1 at pixel 64", sync_cnt, stray_sync); end
        dot_q = cap_q;
    endtask

    task automatic test_backpressure;
        bit ok;
        run_frame(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp frame_done got 0 exp 1"); end
        checks++; if (hold_err !== 0) begin errors++; $display("FAIL bp hold_violations got %0d exp 0", hold_err); end
        checks++; if (cap_q.size() !== NPIX) begin errors++; $display("FAIL bp pixel_count got %0d exp %0d", cap_q.size(), NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            logic [23:0] got;
            got = (i < cap_q.size()) ? cap_q[i] : 24'hx;
            checks++;
            if (got !== dot_q[i] || got !== exp_q[i]) begin errors++; $display("FAIL bp pixel %0d got %h exp %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_line;
        bit ok;
        for (int x = 0; x < W; x++) begin mem[0][x] = (x % 2 == 0) ? 8'd0 : 8'd7; mem[1][x] = 8'd0; end
        line_mode = 1'b1; ch_enable = 2'b01;
        build_expected(1'b1, 2'b01, ch_color);
        run_frame(100, ok);
        checks++; if (!ok || cap_q.size() !== NPIX) begin errors++; $display("FAIL line pixel_count got %0d exp %0d", cap_q.size(), NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            logic [23:0] got;
            got = (i < cap_q.size()) ? cap_q[i] : 24'hx;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL line pixel %0d got %h exp %h", i, got, exp_q[i]); end
        end
        for (int y = 0; y < H; y++) begin
            logic [23:0] c1, c0;
            c1 = (cap_q.size() == NPIX) ? cap_q[(H-1-y)*W + 1] : 24'hx;
            c0 = (cap_q.size() == NPIX) ? cap_q[(H-1-y)*W] : 24'hx;
            checks++;
            if (c1 !== RED || c0 !== ((y == 0) ? RED : BG))
                begin errors++; $display("FAIL line col0/1 row %0d got %h/%h exp %h/%h", y, c0, c1, (y == 0) ? RED : BG, RED); end
        end
    endtask

    task automatic test_priority;
        bit ok;
        logic [1:0] ens [2];
        logic [23:0] want [2];
        ens[0] = 2'b11; want[0] = RED;
        ens[1] = 2'b10; want[1] = GREEN;
        for (int x = 0; x < W; x++) begin mem[0][x] = 8'd3; mem[1][x] = 8'd3; end
        line_mode = 1'b0;
        for (int t = 0; t < 2; t++) begin
            ch_enable = ens[t];
            build_expected(1'b0, ens[t], ch_color);
            run_frame(100, ok);
            checks++; if (!ok || cap_q.size() !== NPIX) begin errors++; $display("FAIL prio%0d pixel_count got %0d exp %0d", t, cap_q.size(), NPIX); end
            for (int i = 0; i < NPIX; i++) begin
                logic [23:0] got;
                got = (i < cap_q.size()) ? cap_q[i] : 24'hx;
                checks++;
                if (got !== exp_q[i]) begin errors++; $display("FAIL prio%0d pixel %0d got %h exp %h", t, i, got, exp_q[i]); end
            end
            checks++;
            if (cap_q.size() != NPIX || cap_q[(H-1-3)*W + 2] !== want[t])
                begin errors++; $display("FAIL prio%0d row3 colour exp %h", t, want[t]); end
        end
    endtask

    task automatic test_clip;
        bit ok;
        for (int x = 0; x < W; x++) begin mem[0][x] = (x % 2 == 0) ? 8'd2 : 8'd200; mem[1][x] = 8'($urandom_range(255)); end
        ch_enable = 2'b01;
        for (int m = 0; m < 2; m++) begin
            line_mode = m[0];
            build_expected(m[0], 2'b01, ch_color);
            run_frame(100, ok);
            checks++; if (!ok || cap_q.size() !== NPIX) begin errors++; $display("FAIL clip%0d pixel_count got %0d exp %0d", m, cap_q.size(), NPIX); end
            for (int i = 0; i < NPIX; i++) begin
                logic [23:0] got;
                got = (i < cap_q.size()) ? cap_q[i] : 24'hx;
                checks++;
                if (got !== exp_q[i]) begin errors++; $display("FAIL clip%0d pixel %0d got %h exp %h", m, i, got, exp_q[i]); end
            end
        end
    endtask

    task automatic test_random;
        bit ok;
        for (int t = 0; t < 4; t++) begin
            for (int x = 0; x < W; x++) begin
                mem[0][x] = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(7));
                mem[1][x] = 8'($urandom_range(9));
            end
            line_mode = 1'($urandom_range(1));
            ch_enable = 2'($urandom_range(3));
            ch_color  = {24'($urandom), 24'($urandom)};
            build_expected(line_mode, ch_enable, ch_color);
            run_frame(70, ok);
            checks++; if (!ok || cap_q.size() !== NPIX || hold_err !== 0)
                begin errors++; $display("FAIL rand%0d pixel_count got %0d holds %0d exp %0d", t, cap_q.size(), hold_err, NPIX); end
            for (int i = 0; i < NPIX; i++) begin
                logic [23:0] got;
                got = (i < cap_q.size()) ? cap_q[i] : 24'hx;
                checks++;
                if (got !== exp_q[i]) begin errors++; $display("FAIL rand%0d pixel %0d got %h exp %h", t, i, got, exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit reached;
        for (int x = 0; x < W; x++) begin mem[0][x] = 8'(x); mem[1][x] = 8'(W - 1 - x); end
        line_mode = 1'b0; ch_enable = 2'b11; ch_color = {GREEN, RED};
        cap_q.delete(); ctrl_cnt = 0;
        reached = 1'b0;
        run = 1'b1; video_ready = 1'b1;
        for (int b = 0; b < 500; b++) begin
            @(posedge clk); #1;
            if (cap_q.size() >= 30) begin reached = 1'b1; break; end
        end
        checks++; if (!reached) begin errors++; $display("FAIL rstmid reach_pixel30 got %0d exp 30", cap_q.size()); end
        rst = 1'b1; run = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if (video_valid !== 1'b0 || video_data !== 24'h0 || ram_rd !== 1'b0 || ram_addr !== 3'd0 ||
                out_control_valid !== 1'b0 || frame_sync !== 1'b0)
                begin errors++; $display("FAIL rstmid outputs_in_reset got v=%b d=%h rd=%b a=%0d exp all 0", video_valid, video_data, ram_rd, ram_addr); end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        build_expected(1'b0, 2'b11, ch_color);
        run_frame(100, ok);
        checks++; if (ctrl_cnt !== 1) begin errors++; $display("FAIL rstmid ctrl_pulses got %0d exp 1", ctrl_cnt); end
        checks++; if (!ok || cap_q.size() !== NPIX) begin errors++; $display("FAIL rstmid pixel_count got %0d exp %0d", cap_q.size(), NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            logic [23:0] got;
            got = (i < cap_q.size()) ? cap_q[i] : 24'hx;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL rstmid pixel %0d got %h exp %h", i, got, exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_dot();
        test_backpressure();
        test_line();
        test_priority();
        test_clip();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/y_wave_draw.md
Name: y_wave_draw

Overview:
- Renders up to CHANNELS sample traces into a WIDTH x HEIGHT 24-bit RGB pixel stream for the video pipeline.
- Each column x reads one sample per channel from an external synchronous sample RAM. A pixel is lit when its row matches the sample (dot mode) or lies between the previous and current samples (line mode).
- Adds to the single-channel dot renderer: full ready/valid backpressure, per-frame control packet, frame gating by run, multi-channel priority colouring and line mode.

Parameters:
- WIDTH, 256, active pixels per line; 2..65535.
- HEIGHT, 256, active lines per frame; 2..65535.
- X_BITS, 8, x counter / ram_addr width; 2**X_BITS >= WIDTH.
- Y_BITS, 8, sample and y counter width; 2**Y_BITS >= HEIGHT.
- CHANNELS, 2, number of traces; 1..4.
- BG_COLOR, 24'h000000, colour of unlit pixels.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  sampled at frame boundary; 1 = render next frame.
- line_mode  in  1  0 = dot, 1 = line; sampled at frame start.
- ch_color  in  24*CHANNELS  colour of channel k at bits [24k+23:24k].
- ch_enable  in  CHANNELS  per-channel display enable; sampled at frame start.
- ram_addr  out  X_BITS  sample column address.
- ram_rd  out  1  RAM read enable.
- ram_rddata  in  Y_BITS*CHANNELS  channel k sample; valid 1 cycle after ram_rd; RAM holds output while ram_rd=0.
- video_data  out  24  RGB pixel.
- video_valid  out  1  pixel valid.
- video_ready  in  1  sink accepts pixel.
- frame_sync  out  1  1-cycle pulse on acceptance of the last pixel of a frame.
- out_control_data  out  36  {width[15:0], height[15:0], interlace[3:0]=0}.
- out_control_valid  out  1  1-cycle pulse before each frame.

Behaviour:
- Reset values: all outputs 0; x_cnt=0; y_cnt=HEIGHT-1; state IDLE; out_control_data is constant, all other outputs zero.
- FSM:
  - IDLE -> CTRL when run=1.
  - CTRL: assert out_control_valid for exactly 1 cycle; latch line_mode and ch_enable -> ACTIVE.
  - ACTIVE -> DRAIN after the last column read of the last line is issued.
  - DRAIN: wait until the final pixel is accepted, then -> CTRL if run=1, else IDLE.
- Pipeline enable: en = !video_valid | video_ready. ram_rd = en & (state==ACTIVE); ram_addr = x_cnt.
- Stage 1 registers x, y, first-column flag and s1_valid on en. Output register loads on en from stage 1 + ram_rddata.
- Latency: first video_valid 2 cycles after the first ram_rd; afterwards 1 pixel/cycle while video_ready=1.
- Backpressure: video_ready=0 with video_valid=1 holds video_data, all counters and stage 1 (RAM output held since ram_rd=0). No pixel is lost or duplicated.
- Scan order: x from 0 to WIDTH-1; y_cnt from HEIGHT-1 down to 0 (top row shows the highest value); wrap at x=WIDTH-1.
- Hit, channel k: sample s, previous-column sample p (p=s at x=0).
  - Dot mode: y==s.
  - Line mode: min(p,s) <= y <= max(p,s).
  - Samples >= HEIGHT never hit in dot mode and are clipped to HEIGHT-1 in line mode.
  - p is kept per channel per line, updated on each en load; a line is re-read for every y.
- Colour: lowest-index enabled channel with a hit wins; no hit -> BG_COLOR.
- frame_sync = video_valid & video_ready & last x & y==0.
- run=0 mid-frame: the current frame completes; stop happens at the boundary.
- Async rst mid-frame: immediate return to reset values. The next frame starts with a fresh control packet.

Decomposition:
- Package y_wave_pkg holds:
  - state enum {IDLE, CTRL, ACTIVE, DRAIN};
  - control field widths (16/16/4) and the CTRL_LEN constant;
  - RGB_W=24.
- Sub-module y_wave_hit: one per channel (generate loop). Combinational dot/line comparison with clipping, inputs s, p, y, mode.

Test Plan:
- WIDTH=HEIGHT=8, run=1, ch0 RAM = x, dot mode, ready=1 -> control pulse with data {8,8,0}. Row y has ch0 colour only at column x=y; 64 pixels; frame_sync at pixel 64.
- Random video_ready (50%) on the same frame -> pixel sequence identical to the ready=1 capture, with no gaps or duplicates.
- Line mode, ch0 samples 0,7,0,... -> column 1 fully lit, rows 0..7; column 0 lit only at row 0.
- Two channels, same sample 3, colours red and green -> row 3 is red. With ch_enable=2'b10 -> row 3 is green.
- Sample 200 with HEIGHT=8: dot mode gives no lit pixel; line mode from p=2 lights rows 2..7.
- rst asserted at pixel 30 then released with run=1 -> outputs 0 during reset, then a new control pulse and a frame from x=0, y=7.
